// File: rtl/conv_window_array.sv
// conv_window_array
//
// Streaming KxK convolution engine. A SIZExSIZE signed fixed-point feature
// map arrives one pixel at a time in row-major order. K-1 line buffers and a
// KxK window shift register assemble each window. Every window position
// that is complete (row >= K-1 and col >= K-1) yields one rectified
// result, in row-major order.
//
// Weights are loaded serially through w_load/w_in. Writes are accepted only
// while the engine is idle, so the weights cannot change during a frame.
//
// Pipeline, counted from the edge that accepts the window-completing pixel:
//   edge 0 : window register captures the new column
//   edge 1 : K*K products registered
//   edge 2 : adder tree sum registered
//   edge 3 : shift and clamp applied, result and res_valid registered
//
// Build option: define CONV_RELU6_EN to clamp to [0, 6.0] (ReLU6).
// Without it the shifted sum is saturated to the signed DW range.
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   w_load     weight write strobe (ignored while busy)
//   w_in       weight value, row-major order
//   px_valid   qualifies px_in
//   px_in      input pixel, row-major order
//   result     rectified convolution result
//   res_valid  result valid this cycle
//   frame_done one-cycle pulse with the last result of a frame
//   busy       frame in progress (RUN or DRAIN)
module conv_window_array #(
  parameter int DW   = 16,
  parameter int FRAC = 8,
  parameter int K    = 3,
  parameter int SIZE = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          w_load,
  input  logic [DW-1:0] w_in,
  input  logic          px_valid,
  input  logic [DW-1:0] px_in,
  output logic [DW-1:0] result,
  output logic          res_valid,
  output logic          frame_done,
  output logic          busy
);

  localparam int NW  = K * K;
  localparam int PW  = 2 * DW;
  localparam int SW  = 2 * DW + $clog2(NW);
  localparam int CW  = $clog2(SIZE);
  localparam int WCW = $clog2(NW);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state_reg, state_next;
  logic [1:0]       drain_reg, drain_next;

  logic [CW-1:0]    row_reg, col_reg;
  logic [WCW-1:0]   w_cnt_reg;

  logic signed [DW-1:0] weight_reg [NW];
  logic signed [DW-1:0] line_reg   [K-1][SIZE];
  logic signed [DW-1:0] win_reg    [NW];
  logic signed [DW-1:0] new_col    [K];
  logic signed [PW-1:0] prod_reg   [NW];
  logic signed [SW-1:0] sum_next, sum_reg, shifted;
  logic        [DW-1:0] clamp_val;

  logic v1_reg, v2_reg, v3_reg;
  logic l1_reg, l2_reg, l3_reg;

  logic accept, w_write, col_last, row_last, win_done, frame_end;

  assign accept    = px_valid;
  assign busy      = (state_reg != IDLE);
  assign w_write   = w_load && !busy;
  assign col_last  = (col_reg == CW'(SIZE - 1));
  assign row_last  = (row_reg == CW'(SIZE - 1));
  assign win_done  = (row_reg >= CW'(K - 1)) && (col_reg >= CW'(K - 1));
  assign frame_end = accept && row_last && col_last;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      drain_reg <= '0;
    end else begin
      state_reg <= state_next;
      drain_reg <= drain_next;
    end
  end

  // DRAIN lasts three cycles, covering the pipeline tail of the frame.
  // A pixel arriving during DRAIN starts the next frame straight away; the
  // tail keeps flowing because the pipeline never stalls.
  always_comb begin
    state_next = state_reg;
    drain_next = drain_reg;
    unique case (state_reg)
      IDLE: begin
        if (accept) state_next = RUN;
      end
      RUN: begin
        if (frame_end) begin
          state_next = DRAIN;
          drain_next = '0;
        end
      end
      DRAIN: begin
        if (accept) begin
          state_next = RUN;
        end else if (drain_reg == 2'd2) begin
          state_next = IDLE;
        end else begin
          drain_next = drain_reg + 2'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ------------------------------------------------------ pixel counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_reg <= '0;
      col_reg <= '0;
    end else if (accept) begin
      if (col_last) begin
        col_reg <= '0;
        row_reg <= row_last ? '0 : row_reg + 1'b1;
      end else begin
        col_reg <= col_reg + 1'b1;
      end
    end
  end

  // ------------------------------------------------------------ weights
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_cnt_reg <= '0;
      for (int i = 0; i < NW; i++) weight_reg[i] <= '0;
    end else if (w_write) begin
      weight_reg[w_cnt_reg] <= $signed(w_in);
      w_cnt_reg <= (w_cnt_reg == WCW'(NW - 1)) ? '0 : w_cnt_reg + 1'b1;
    end
  end

  // ------------------------------------------- line buffers and window
  // Column entering the window: index K-1 is the live pixel, lower indices
  // are the same column from progressively older rows.
  always_comb begin
    for (int k = 0; k < K - 1; k++) new_col[k] = line_reg[k][col_reg];
    new_col[K-1] = $signed(px_in);
  end

  // Each line buffer row moves up by one as the new column passes through,
  // so line_reg[k] always holds the row K-1-k above the current one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < K - 1; k++)
        for (int c = 0; c < SIZE; c++) line_reg[k][c] <= '0;
      for (int i = 0; i < NW; i++) win_reg[i] <= '0;
    end else if (accept) begin
      for (int k = 0; k < K - 1; k++) line_reg[k][col_reg] <= new_col[k+1];
      for (int k = 0; k < K; k++) begin
        for (int j = 0; j < K - 1; j++) win_reg[k*K+j] <= win_reg[k*K+j+1];
        win_reg[k*K+K-1] <= new_col[k];
      end
    end
  end

  // ------------------------------------------------------- multipliers
  for (genvar gi = 0; gi < NW; gi++) begin : g_mul
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prod_reg[gi] <= '0;
      else        prod_reg[gi] <= PW'(win_reg[gi]) * PW'(weight_reg[gi]);
    end
  end

  // -------------------------------------------------------- adder tree
  always_comb begin
    sum_next = '0;
    for (int i = 0; i < NW; i++) sum_next = sum_next + SW'(prod_reg[i]);
  end

  // Arithmetic shift floors toward minus infinity.
  assign shifted = sum_reg >>> FRAC;

`ifdef CONV_RELU6_EN
  localparam logic signed [SW-1:0] RELU6_MAX = SW'(64'sd6 <<< FRAC);

  always_comb begin
    clamp_val = DW'(shifted);
    if (shifted[SW-1])             clamp_val = '0;
    else if (shifted > RELU6_MAX)  clamp_val = DW'(RELU6_MAX);
  end
`else
  localparam logic signed [SW-1:0] SAT_MAX = SW'((64'sd1 <<< (DW - 1)) - 64'sd1);
  localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

  always_comb begin
    clamp_val = DW'(shifted);
    if (shifted > SAT_MAX)      clamp_val = DW'(SAT_MAX);
    else if (shifted < SAT_MIN) clamp_val = DW'(SAT_MIN);
  end
`endif

  // ----------------------------------------- valid tags and output regs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_reg     <= 1'b0;
      v2_reg     <= 1'b0;
      v3_reg     <= 1'b0;
      l1_reg     <= 1'b0;
      l2_reg     <= 1'b0;
      l3_reg     <= 1'b0;
      sum_reg    <= '0;
      result     <= '0;
      res_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      v1_reg     <= accept && win_done;
      l1_reg     <= frame_end;
      v2_reg     <= v1_reg;
      l2_reg     <= l1_reg;
      v3_reg     <= v2_reg;
      l3_reg     <= l2_reg;
      sum_reg    <= sum_next;
      res_valid  <= v3_reg;
      frame_done <= l3_reg;
      if (v3_reg) result <= clamp_val;
    end
  end

endmodule

// File: doc/conv_window_array.md
# conv_window_array

Parametrised K×K convolution engine for the CNN datapath. It streams a SIZE×SIZE signed fixed-point feature map in row-major order and holds K×K weights that are loaded serially. Internal line buffers build each window; the block emits one rectified result per valid window position in row-major order. It sits between the feature-map source and the pooling stage. It generalises the fixed 3×3 array to any kernel size, data width and map size, and adds per-pixel valid qualification, back-to-back frames and an explicit frame-done handshake.

## Interface
- DW, 16: data and weight width, signed two's complement
- FRAC, 8: fractional bits of the fixed-point format (1.0 = 1<<FRAC)
- K, 3: kernel edge; legal range 2..7
- SIZE, 7: input map edge; must be ≥ K; output edge is SIZE-K+1

- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- w_load  in  1  weight write strobe
- w_in  in  DW  weight value, row-major order
- px_valid  in  1  qualifies px_in
- px_in  in  DW  input pixel, row-major order
- result  out  DW  rectified convolution result
- res_valid  out  1  result is valid this cycle
- frame_done  out  1  one-cycle pulse coincident with the last result of a frame
- busy  out  1  a frame is in progress; weight writes are ignored

## Operation
- **Weights:** when w_load=1 and busy=0, w_in is written to weight[w_cnt] and w_cnt increments. w_cnt wraps from K*K-1 to 0. A w_load while busy=1 is dropped and w_cnt does not change.
- **Pixel counters:** row and col count accepted pixels (px_valid=1). col wraps at SIZE-1 and increments row. After pixel (SIZE-1, SIZE-1), both return to 0 and the next accepted pixel starts a new frame.
- **Line buffers:** K-1 rows of SIZE entries plus a K×K window shift register. All advance only on accepted pixels.
- **Window valid:** a pixel at (row, col) with row ≥ K-1 and col ≥ K-1 completes a window. Data left over from a previous frame is never used, because validity is gated by row and col.
- **Arithmetic:**
  - Each product is 2*DW bits.
  - The sum is 2*DW + ceil(log2(K*K)) bits, so the K*K accumulation cannot overflow.
  - The sum is arithmetic-shifted right by FRAC, which truncates toward −∞.
  - The shifted value is then clamped per Configuration.
- **FSM states:**
  - IDLE → RUN on an accepted pixel.
  - RUN → DRAIN on acceptance of the last pixel of the frame.
  - DRAIN → IDLE after 3 cycles.
  - An accepted pixel during DRAIN begins the next frame and moves the FSM to RUN; the draining results still emerge.
- **busy:** 1 in RUN and DRAIN, 0 in IDLE.
- **Reset:** clears the FSM, counters, w_cnt, weights, line buffers and pipeline. All outputs reset to 0 (result=0, res_valid=0, frame_done=0, busy=0). A reset in mid-frame discards the partial frame, and no result or frame_done is emitted for it.

## Timing
- **Pipeline:** 3 stages: window register → K*K multipliers → adder tree, shift and clamp.
- **Latency:** res_valid rises exactly 3 cycles after the clk edge that accepts the window-completing pixel.
- **No stalls:** the pipeline runs every cycle with a valid tag. Gaps in px_valid produce matching gaps in res_valid; results are never reordered or dropped.
- **Throughput:** one pixel per cycle, giving (SIZE-K+1)² results per frame.
- **frame_done:** asserted in the same cycle as res_valid for window (SIZE-K, SIZE-K).
- **Weight changes:** a weight write takes effect for the next frame. Weights are stable throughout a frame because writes are blocked while busy.
- **Simultaneous w_load and px_valid in IDLE:** the weight write is taken and the pixel is accepted; the new frame uses the updated weight.

## Configuration
- **CONV_RELU6_EN defined:** result = min(max(v, 0), 6<<FRAC), i.e. ReLU6.
- **CONV_RELU6_EN undefined:** result = v saturated to the signed DW range [-2^(DW-1), 2^(DW-1)-1], with no rectification.

## Test plan
- **Ones kernel, defaults, macro on:** all weights 256, all pixels 256 → 25 results of 1536, frame_done on the 25th, busy drops 3 cycles later. Same stimulus with the macro off → 2304.
- **Identity kernel:** centre weight 256, others 0; pixel(r,c) = r*7+c → result(i,j) = (i+1)*7+(j+1), i.e. first 8, last 40.
- **Negative and saturation:** all weights -256, pixels 256 → macro on: 0; macro off: -2304. With weights 32767 and pixels 32767, macro off → 32767.
- **Bubbles and back-to-back frames:** px_valid toggles 1,0 → results identical to the dense run, each 3 cycles after its completing pixel. A second frame started in DRAIN produces 25 more results and a second frame_done.
- **Blocked weight write:** w_load asserted with w_in=0 during RUN → ignored; frame results unchanged, w_cnt unchanged.
- **Mid-frame reset:** rst_n low after 20 pixels → all outputs 0 immediately, no frame_done. Reload weights and send a full frame → correct 25 results.
